byte_serial_adder: RTL and testbench
====================================

# byte_serial_adder

Multi-byte adder sequencer that wraps one 8-bit hybrid adder (`hybridadder8_struct`) and processes a wide operand pair one byte per clock, least-significant byte first. It sits directly upstream and downstream of that adder. It registers the operands, presents byte slices and the running carry to the adder's X/Y/C0 inputs, and collects the adder's S/C8 outputs into a result register. A start/busy/done handshake connects it to the controlling logic.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..16.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  request; accepted only in IDLE.
- A  input  8*NBYTES  operand A; sampled on the accepting edge.
- B  input  8*NBYTES  operand B; sampled on the accepting edge.
- CIN  input  1  carry-in; sampled on the accepting edge.
- SUB  input  1  subtract request; port present only with ADDSEQ_SUB_EN.
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse in DONE state.
- SUM  output  8*NBYTES  result register.
- COUT  output  1  final carry out of the top byte.
- OVF  output  1  signed (two's-complement) overflow of the full-width result.

## Operation
- States: IDLE, RUN, DONE. Byte index IDX has width clog2(NBYTES), minimum 1 bit. Carry register CR is 1 bit.
- IDLE with START=1: latch A, B and CIN into operand registers. Set CR=CIN and IDX=0, then go to RUN. SUM, COUT and OVF keep their previous values until they are overwritten.
- IDLE with START=0: stay in IDLE.
- RUN, on each edge:
  - SUM[8*IDX +: 8] <= adder S, where the adder inputs are X = A_reg byte IDX, Y = B_reg byte IDX, C0 = CR.
  - CR <= adder C8.
  - If IDX == NBYTES-1: COUT <= C8, OVF <= (A_msb == B_msb) & (S_msb != A_msb), and go to DONE.
  - Otherwise IDX <= IDX+1.
- DONE: DONE=1 and BUSY=0 for exactly one cycle, then go to IDLE unconditionally.
- START is ignored in RUN and in DONE. It is not queued.
- The adder instance is purely combinational. Its inputs come from registers only.
- Arithmetic is modulo 2^(8*NBYTES). COUT is the true carry out of the MSB.
- NBYTES=1: RUN lasts one cycle.
- Input changes on A, B or CIN after acceptance have no effect on the operation in progress.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0, CR=0, IDX=0, operand registers=0.
- Reset asserted mid-operation aborts the operation immediately:
  - all outputs return to their reset values;
  - no DONE pulse is produced;
  - the first edge after deassertion sees IDLE.
- Accepting edge = edge E. BUSY is high from after E through after edge E+NBYTES-1.
- DONE is high during the cycle following edge E+NBYTES. SUM, COUT and OVF are final and stable from that point.
- Total latency from START acceptance to the DONE pulse: NBYTES+1 edges.
- The earliest next acceptance is on the edge at which DONE is high→IDLE transition completes, i.e. edge E+NBYTES+1 leaves DONE and edge E+NBYTES+2 can accept. Minimum issue interval: NBYTES+2 cycles.
- SUM bytes update progressively during RUN. Only the value present while DONE is high is defined as the result.

## Configuration
- ADDSEQ_SUB_EN defined:
  - the SUB port exists and is sampled on the accepting edge;
  - when SUB=1, B_reg stores ~B and CR initialises to 1 (CIN is ignored), so the result is A−B;
  - COUT=1 means no borrow;
  - OVF uses the inverted B MSB.
- ADDSEQ_SUB_EN undefined: no SUB port, and the block performs addition only.

## Test plan
- NBYTES=4, A=0xFFFFFFFF, B=0x00000001, CIN=0, START pulse → DONE 5 edges after acceptance, SUM=0x00000000, COUT=1, OVF=0, BUSY high for 4 cycles.
- A=0x7FFFFFFF, B=0x00000001, CIN=0 → SUM=0x80000000, COUT=0, OVF=1.
- A=0x12345678, B=0x11111111, CIN=1, with START held high through RUN and a second operand set applied mid-run → SUM=0x2345678A, exactly one DONE pulse, second request not accepted.
- Accept A=0x01010101, B=0x01010101, assert RST at the 2nd RUN edge → all outputs 0 with no DONE pulse. A new START after release gives SUM=0x02020202.
- With ADDSEQ_SUB_EN: A=5, B=7, SUB=1 → SUM=0xFFFFFFFE, COUT=0, OVF=0. A=0x80000000, B=1, SUB=1 → SUM=0x7FFFFFFF, OVF=1.
- NBYTES=1, A=0xF0, B=0x20, CIN=0 → DONE 2 edges after acceptance, SUM=0x10, COUT=1. Back-to-back STARTs accepted every 3 cycles.

Source files
------------

// File: rtl/byte_serial_adder_if.sv
// Handshake and operand/result bundle for byte_serial_adder.
// SUB exists only when ADDSEQ_SUB_EN is defined.
interface byte_serial_adder_if #(
    parameter int NBYTES = 4
);
    logic                  START;
    logic [8*NBYTES-1:0]   A;
    logic [8*NBYTES-1:0]   B;
    logic                  CIN;
`ifdef ADDSEQ_SUB_EN
    logic                  SUB;
`endif
    logic                  BUSY;
    logic                  DONE;
    logic [8*NBYTES-1:0]   SUM;
    logic                  COUT;
    logic                  OVF;
    logic [1:0]            dbg_state;

`ifdef ADDSEQ_SUB_EN
    modport master (output START, A, B, CIN, SUB,
                    input  BUSY, DONE, SUM, COUT, OVF, dbg_state);
    modport slave  (input  START, A, B, CIN, SUB,
                    output BUSY, DONE, SUM, COUT, OVF, dbg_state);
`else
    modport master (output START, A, B, CIN,
                    input  BUSY, DONE, SUM, COUT, OVF, dbg_state);
    modport slave  (input  START, A, B, CIN,
                    output BUSY, DONE, SUM, COUT, OVF, dbg_state);
`endif
endinterface

// File: rtl/byte_serial_adder.sv
// Byte-serial multi-byte adder around one 8-bit hybrid adder, LSB byte first.
// Optional subtract mode is enabled by defining ADDSEQ_SUB_EN.
//
// Handshake: START is sampled only in IDLE; the accepting edge latches A/B/CIN.
// BUSY is high while in RUN, DONE pulses for one cycle when SUM/COUT/OVF are final.
// START seen in RUN or DONE is dropped, not queued.

module hybridadder8_struct (
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic       C0,
    output logic [7:0] S,
    output logic       C8
);
    logic [4:0] lo_w;
    logic [4:0] hi0_w;
    logic [4:0] hi1_w;

    // Ripple low nibble, carry-select high nibble.
    assign lo_w  = {1'b0, X[3:0]} + {1'b0, Y[3:0]} + {4'b0000, C0};
    assign hi0_w = {1'b0, X[7:4]} + {1'b0, Y[7:4]};
    assign hi1_w = {1'b0, X[7:4]} + {1'b0, Y[7:4]} + 5'd1;

    assign S  = {(lo_w[4] ? hi1_w[3:0] : hi0_w[3:0]), lo_w[3:0]};
    assign C8 = lo_w[4] ? hi1_w[4] : hi0_w[4];
endmodule

module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    byte_serial_adder_if.slave  bus
);
    localparam int W   = 8 * NBYTES;
    localparam int IW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic            cr_q;
    logic            cout_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      x_w;
    logic [7:0]      y_w;
    logic [7:0]      s_w;
    logic            c8_w;
    logic            last_w;

    // Adder inputs come straight from registers only.
    assign x_w    = a_q[8*idx_q +: 8];
    assign y_w    = b_q[8*idx_q +: 8];
    assign idx_d  = idx_q + 1'b1;
    assign last_w = (idx_q == IW'(NBYTES - 1));

    hybridadder8_struct u_add (
        .X  (x_w),
        .Y  (y_w),
        .C0 (cr_q),
        .S  (s_w),
        .C8 (c8_w)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cr_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        a_q    <= bus.A;
`ifdef ADDSEQ_SUB_EN
                        // Subtract as A + ~B + 1; CIN is ignored then.
                        b_q    <= bus.SUB ? ~bus.B : bus.B;
                        cr_q   <= bus.SUB | bus.CIN;
`else
                        b_q    <= bus.B;
                        cr_q   <= bus.CIN;
`endif
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[8*idx_q +: 8] <= s_w;
                    cr_q                <= c8_w;
                    if (last_w) begin
                        cout_q  <= c8_w;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) & (s_w[7] != a_q[W-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.SUM       = sum_q;
    assign bus.COUT      = cout_q;
    assign bus.OVF       = ovf_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder: a 4-byte and a 1-byte instance on one clock.
// Subtract vectors are included when ADDSEQ_SUB_EN is defined.
module tb_byte_serial_adder;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    logic [31:0] exp_q[$];

    byte_serial_adder_if #(.NBYTES(4)) bus4 ();
    byte_serial_adder_if #(.NBYTES(1)) bus1 ();

    byte_serial_adder #(.NBYTES(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(bus4));
    byte_serial_adder #(.NBYTES(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 4-byte operation; samples every negedge for a fixed window after acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic hold,
                          output int lat, output int busy_n, output int done_n,
                          output logic [31:0] sum_s, output logic cout_s, output logic ovf_s);
        @(negedge CLK);
        bus4.A     = a;
        bus4.B     = b;
        bus4.CIN   = cin;
`ifdef ADDSEQ_SUB_EN
        bus4.SUB   = sub;
`else
        if (sub) $display("note: subtract vector skipped in add-only build");
`endif
        bus4.START = 1'b1;
        @(negedge CLK);
        if (!hold) bus4.START = 1'b0;
        lat    = 0;
        busy_n = 0;
        done_n = 0;
        sum_s  = 'x;
        cout_s = 1'bx;
        ovf_s  = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            if (bus4.BUSY) busy_n++;
            if (bus4.DONE) begin
                done_n++;
                if (lat == 0) begin
                    lat    = i;
                    sum_s  = bus4.SUM;
                    cout_s = bus4.COUT;
                    ovf_s  = bus4.OVF;
                end
                bus4.START = 1'b0;
            end
            if (hold && i == 2) begin
                bus4.A   = 32'hFFFF_FFFF;
                bus4.B   = 32'hFFFF_FFFF;
                bus4.CIN = 1'b1;
            end
            @(negedge CLK);
        end
        bus4.START = 1'b0;
    endtask

    task automatic op_and_score(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub, input logic hold,
                                input logic exp_cout, input logic exp_ovf);
        int lat, busy_n, done_n;
        logic [31:0] sum_s;
        logic cout_s, ovf_s;
        logic [31:0] exp_sum;
        run_op(a, b, cin, sub, hold, lat, busy_n, done_n, sum_s, cout_s, ovf_s);
        exp_sum = exp_q.pop_front();
        chk({tag, "_sum"},  sum_s, exp_sum);
        chk({tag, "_cout"}, {31'd0, cout_s}, {31'd0, exp_cout});
        chk({tag, "_ovf"},  {31'd0, ovf_s},  {31'd0, exp_ovf});
        chk({tag, "_lat"},  lat, 5);
        chk({tag, "_busy"}, busy_n, 4);
        chk({tag, "_done"}, done_n, 1);
    endtask

    initial begin
        int lat, busy_n, done_n;
        logic [8:0] mask;
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus4.START = 1'b0; bus4.A = '0; bus4.B = '0; bus4.CIN = 1'b0;
        bus1.START = 1'b0; bus1.A = '0; bus1.B = '0; bus1.CIN = 1'b0;
`ifdef ADDSEQ_SUB_EN
        bus4.SUB = 1'b0;
        bus1.SUB = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        chk("rst_sum",   bus4.SUM, 32'h0);
        chk("rst_busy",  {31'd0, bus4.BUSY}, 32'd0);
        chk("rst_done",  {31'd0, bus4.DONE}, 32'd0);
        chk("rst_cout",  {31'd0, bus4.COUT}, 32'd0);
        chk("rst_ovf",   {31'd0, bus4.OVF},  32'd0);
        chk("rst_state", {30'd0, bus4.dbg_state}, 32'd0);
        RST = 1'b0;

        exp_q.push_back(32'h2345_678A);
        op_and_score("hold", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'h8000_0000);
        op_and_score("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort mid-run: reset between the first and second RUN edges.
        @(negedge CLK);
        bus4.A = 32'h0101_0101; bus4.B = 32'h0101_0101; bus4.CIN = 1'b0; bus4.START = 1'b1;
        @(negedge CLK);
        bus4.START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort_sum",  bus4.SUM, 32'h0);
        chk("abort_busy", {31'd0, bus4.BUSY}, 32'd0);
        chk("abort_ovf",  {31'd0, bus4.OVF},  32'd0);
        chk("abort_state", {30'd0, bus4.dbg_state}, 32'd0);
        done_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus4.DONE) done_n++;
        end
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (bus4.DONE || bus4.BUSY) done_n++;
        end
        chk("abort_no_done", done_n, 0);
        exp_q.push_back(32'h0202_0202);
        op_and_score("after_rst", 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        exp_q.push_back(32'h0000_0000);
        op_and_score("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef ADDSEQ_SUB_EN
        exp_q.push_back(32'hFFFF_FFFE);
        op_and_score("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h7FFF_FFFF);
        op_and_score("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        bus4.SUB = 1'b0;
`endif

        // Single-byte instance: latency and back-to-back issue.
        @(negedge CLK);
        bus1.A = 8'hF0; bus1.B = 8'h20; bus1.CIN = 1'b0; bus1.START = 1'b1;
        @(negedge CLK);
        bus1.START = 1'b0;
        lat = 0; busy_n = 0; done_n = 0;
        for (int i = 1; i <= 6; i++) begin
            if (bus1.BUSY) busy_n++;
            if (bus1.DONE) begin
                done_n++;
                if (lat == 0) begin
                    lat = i;
                    chk("b1_sum",  {24'd0, bus1.SUM}, 32'h10);
                    chk("b1_cout", {31'd0, bus1.COUT}, 32'd1);
                    chk("b1_ovf",  {31'd0, bus1.OVF},  32'd0);
                end
            end
            @(negedge CLK);
        end
        chk("b1_lat",  lat, 2);
        chk("b1_busy", busy_n, 1);
        chk("b1_done", done_n, 1);

        bus1.START = 1'b1;
        @(negedge CLK);
        mask = '0;
        for (int i = 1; i <= 9; i++) begin
            mask[i-1] = bus1.DONE;
            @(negedge CLK);
        end
        bus1.START = 1'b0;
        chk("b1_b2b_pattern", {23'd0, mask}, 32'h092);

        repeat (4) @(negedge CLK);
        chk("final_idle4", {30'd0, bus4.dbg_state}, 32'd0);
        chk("final_idle1", {30'd0, bus1.dbg_state}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
